// File: rtl/scale_pkg.sv
// Shared types and constants for the framebuffer scaling sequencer.
package scale_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    WAIT_VSYNC = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BAD_OP  = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ABORTED = 2'd3
  } status_e;

  localparam int OP_W  = 3;
  localparam int CNT_W = 18;

  localparam logic [OP_W-1:0] OP_NN    = 3'd0;
  localparam logic [OP_W-1:0] OP_REPL  = 3'd1;
  localparam logic [OP_W-1:0] OP_DECIM = 3'd2;
  localparam logic [OP_W-1:0] OP_AVG   = 3'd3;

  localparam int IMG_IN_W    = 160;
  localparam int IMG_IN_H    = 120;
  localparam int IMG_OUT_W   = 320;
  localparam int IMG_OUT_H   = 240;
  localparam int IMG_OUT_PIX = IMG_OUT_W * IMG_OUT_H;

endpackage

// File: rtl/scale_port_mux.sv
// Selects the active engine's address/pixel slices and done bit; ports read 0 when not enabled.
module scale_port_mux
  import scale_pkg::*;
#(
  parameter int NUM_ALG = 4,
  parameter int ADDR_W  = 16,
  parameter int PIX_W   = 8
) (
  input  logic [OP_W-1:0]                 i_sel,
  input  logic                            i_en,
  input  logic [NUM_ALG-1:0][ADDR_W-1:0]  i_rd_addr,
  input  logic [NUM_ALG-1:0][ADDR_W-1:0]  i_wr_addr,
  input  logic [NUM_ALG-1:0][PIX_W-1:0]   i_pix,
  input  logic [NUM_ALG-1:0]              i_done,
  output logic [ADDR_W-1:0]               o_rd_addr,
  output logic [ADDR_W-1:0]               o_wr_addr,
  output logic [PIX_W-1:0]                o_pix,
  output logic                            o_done
);

  always_comb begin
    o_rd_addr = '0;
    o_wr_addr = '0;
    o_pix     = '0;
    o_done    = 1'b0;
    for (int k = 0; k < NUM_ALG; k++) begin
      if (i_sel == OP_W'(k)) begin
        o_done = i_done[k];
        if (i_en) begin
          o_rd_addr = i_rd_addr[k];
          o_wr_addr = i_wr_addr[k];
          o_pix     = i_pix[k];
        end
      end
    end
  end

endmodule

// File: rtl/scale_ctrl.sv
// Scaling-engine sequencer: one command at a time, engine port mux, run timeout,
// and display-bank swap on the first vsync rising edge after completion.
module scale_ctrl
  import scale_pkg::*;
#(
  parameter int NUM_ALG        = 4,
  parameter int ADDR_W         = 16,
  parameter int PIX_W          = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic [OP_W-1:0]             i_cmd_op,
  input  logic                        i_cmd_abort,
  input  logic                        i_vsync,
  output logic [NUM_ALG-1:0]          o_alg_enable,
  input  logic [NUM_ALG-1:0]          i_alg_done,
  input  logic [NUM_ALG*ADDR_W-1:0]   i_alg_read_addr,
  input  logic [NUM_ALG*ADDR_W-1:0]   i_alg_write_addr,
  input  logic [NUM_ALG*PIX_W-1:0]    i_alg_pixel,
  output logic [ADDR_W-1:0]           o_mem_read_addr,
  output logic [ADDR_W-1:0]           o_mem_write_addr,
  output logic [PIX_W-1:0]            o_mem_wdata,
  output logic                        o_mem_we,
  output logic                        o_write_bank,
  output logic                        o_display_bank,
  output logic                        o_busy,
  output logic                        o_done_pulse,
  output logic [1:0]                  o_status
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              r_state, w_state_nxt;
  status_e             r_status, w_status_nxt;
  logic [OP_W-1:0]     r_sel, w_sel_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [NUM_ALG-1:0]  r_alg_en, w_alg_en_nxt;
  logic                r_vs_q;
  logic                r_bank, w_bank_nxt;
  logic                r_done_pulse, w_done_nxt;
  logic                w_run, w_vs_rise, w_done_sel;

  assign w_run     = (r_state == RUN);
  assign w_vs_rise = i_vsync & ~r_vs_q;

  scale_port_mux #(
    .NUM_ALG (NUM_ALG),
    .ADDR_W  (ADDR_W),
    .PIX_W   (PIX_W)
  ) u_mux (
    .i_sel     (r_sel),
    .i_en      (w_run),
    .i_rd_addr (i_alg_read_addr),
    .i_wr_addr (i_alg_write_addr),
    .i_pix     (i_alg_pixel),
    .i_done    (i_alg_done),
    .o_rd_addr (o_mem_read_addr),
    .o_wr_addr (o_mem_write_addr),
    .o_pix     (o_mem_wdata),
    .o_done    (w_done_sel)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_sel_nxt    = r_sel;
    w_cnt_nxt    = r_cnt;
    w_bank_nxt   = r_bank;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_cmd_valid) begin
          w_sel_nxt = i_cmd_op;
          if (int'(i_cmd_op) >= NUM_ALG) begin
            w_done_nxt   = 1'b1;
            w_status_nxt = ST_BAD_OP;
          end else begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end
        end
      end
      RUN: begin
        if (r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
        // Completion outranks abort so a finished frame is never thrown away.
        if (w_done_sel) begin
          w_state_nxt = WAIT_VSYNC;
        end else if (i_cmd_abort) begin
          w_state_nxt  = IDLE;
          w_done_nxt   = 1'b1;
          w_status_nxt = ST_ABORTED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = IDLE;
          w_done_nxt   = 1'b1;
          w_status_nxt = ST_TIMEOUT;
        end
      end
      WAIT_VSYNC: begin
        if (i_cmd_abort) begin
          w_state_nxt  = IDLE;
          w_done_nxt   = 1'b1;
          w_status_nxt = ST_ABORTED;
        end else if (w_vs_rise) begin
          w_bank_nxt   = ~r_bank;
          w_state_nxt  = IDLE;
          w_done_nxt   = 1'b1;
          w_status_nxt = ST_OK;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Enable is registered from the next state so it drops the cycle after RUN ends.
    w_alg_en_nxt = '0;
    for (int k = 0; k < NUM_ALG; k++)
      w_alg_en_nxt[k] = (w_state_nxt == RUN) && (w_sel_nxt == OP_W'(k));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_status     <= ST_OK;
      r_sel        <= '0;
      r_cnt        <= '0;
      r_alg_en     <= '0;
      r_vs_q       <= 1'b0;
      r_bank       <= 1'b0;
      r_done_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_status     <= w_status_nxt;
      r_sel        <= w_sel_nxt;
      r_cnt        <= w_cnt_nxt;
      r_alg_en     <= w_alg_en_nxt;
      r_vs_q       <= i_vsync;
      r_bank       <= w_bank_nxt;
      r_done_pulse <= w_done_nxt;
    end
  end

  assign o_cmd_ready    = (r_state == IDLE);
  assign o_busy         = (r_state != IDLE);
  assign o_alg_enable   = r_alg_en;
  assign o_mem_we       = w_run & ~w_done_sel;
  assign o_display_bank = r_bank;
  assign o_write_bank   = ~r_bank;
  assign o_done_pulse   = r_done_pulse;
  assign o_status       = r_status;

endmodule

// File: tb/tb_scale_ctrl.sv
// Directed bench for scale_ctrl: vector table for opcode/mux behaviour plus hand-written
// sequences for completion, vsync swap, abort races, timeout and async reset.
module tb_scale_ctrl;
  import scale_pkg::*;

  localparam int NA = 4;
  localparam int AW = 16;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            cmd_valid = 1'b0;
  logic [2:0]      cmd_op    = '0;
  logic            cmd_abort = 1'b0;
  logic            vsync     = 1'b0;
  logic [NA-1:0]   alg_done  = '0;
  logic [NA*AW-1:0] rd_sl, wr_sl;
  logic [NA*PW-1:0] px_sl;

  logic            cmd_ready, mem_we, write_bank, display_bank, busy, done_pulse;
  logic [NA-1:0]   alg_enable;
  logic [AW-1:0]   mem_read_addr, mem_write_addr;
  logic [PW-1:0]   mem_wdata;
  logic [1:0]      status;

  logic            t_cmd_ready, t_mem_we, t_write_bank, t_display_bank, t_busy, t_done_pulse;
  logic [NA-1:0]   t_alg_enable;
  logic [AW-1:0]   t_mem_read_addr, t_mem_write_addr;
  logic [PW-1:0]   t_mem_wdata;
  logic [1:0]      t_status;

  scale_ctrl #(.NUM_ALG(NA), .ADDR_W(AW), .PIX_W(PW), .TIMEOUT_CYCLES(100000)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_abort(cmd_abort), .i_vsync(vsync), .o_alg_enable(alg_enable),
    .i_alg_done(alg_done), .i_alg_read_addr(rd_sl), .i_alg_write_addr(wr_sl),
    .i_alg_pixel(px_sl), .o_mem_read_addr(mem_read_addr), .o_mem_write_addr(mem_write_addr),
    .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .o_write_bank(write_bank),
    .o_display_bank(display_bank), .o_busy(busy), .o_done_pulse(done_pulse), .o_status(status)
  );

  // Short-timeout copy sharing the same stimulus, used for the timeout sequence.
  scale_ctrl #(.NUM_ALG(NA), .ADDR_W(AW), .PIX_W(PW), .TIMEOUT_CYCLES(100)) dut_to (
    .i_clk(clk), .i_reset_n(reset_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(t_cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_abort(cmd_abort), .i_vsync(vsync), .o_alg_enable(t_alg_enable),
    .i_alg_done(alg_done), .i_alg_read_addr(rd_sl), .i_alg_write_addr(wr_sl),
    .i_alg_pixel(px_sl), .o_mem_read_addr(t_mem_read_addr), .o_mem_write_addr(t_mem_write_addr),
    .o_mem_wdata(t_mem_wdata), .o_mem_we(t_mem_we), .o_write_bank(t_write_bank),
    .o_display_bank(t_display_bank), .o_busy(t_busy), .o_done_pulse(t_done_pulse),
    .o_status(t_status)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  en;
    logic [15:0] rd;
    logic [15:0] wr;
    logic [7:0]  px;
    logic [1:0]  st;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n, we_cnt, en_bad, dp;

    rd_sl = {16'h1234, 16'h0C02, 16'h0B01, 16'h0A00};
    wr_sl = {16'hBEEF, 16'hD002, 16'hD001, 16'hD000};
    px_sl = {8'hA5, 8'h33, 8'h22, 8'h11};

    vt[0] = '{OP_AVG,   4'b1000, 16'h1234, 16'hBEEF, 8'hA5, 2'd3};
    vt[1] = '{OP_NN,    4'b0001, 16'h0A00, 16'hD000, 8'h11, 2'd3};
    vt[2] = '{OP_REPL,  4'b0010, 16'h0B01, 16'hD001, 8'h22, 2'd3};
    vt[3] = '{OP_DECIM, 4'b0100, 16'h0C02, 16'hD002, 8'h33, 2'd3};
    vt[4] = '{3'd5,     4'b0000, 16'h0000, 16'h0000, 8'h00, 2'd1};
    vt[5] = '{3'd4,     4'b0000, 16'h0000, 16'h0000, 8'h00, 2'd1};
    vt[6] = '{3'd7,     4'b0000, 16'h0000, 16'h0000, 8'h00, 2'd1};
    vt[7] = '{3'd6,     4'b0000, 16'h0000, 16'h0000, 8'h00, 2'd1};

    // Reset state: {ready,en,rd,wr,pix,we,wbank,dbank,busy,done,status}
    #3;
    chk("reset_outputs",
        {cmd_ready, alg_enable, mem_read_addr, mem_write_addr, mem_wdata, mem_we,
         write_bank, display_bank, busy, done_pulse, status},
        {1'b1, 4'b0, 16'h0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // Opcode table: valid ops check mux then abort; invalid ops give BAD_OP.
    for (int i = 0; i < 8; i++) begin
      cmd_op = vt[i].op; cmd_valid = 1'b1; #1;
      chk("tbl_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0; #1;
      chk("tbl_enable", alg_enable, vt[i].en);
      chk("tbl_rd_addr", mem_read_addr, vt[i].rd);
      chk("tbl_wr_addr", mem_write_addr, vt[i].wr);
      chk("tbl_wdata", mem_wdata, vt[i].px);
      if (vt[i].en == 4'b0000) begin
        chk("tbl_bad_ready", cmd_ready, 1'b1);
        chk("tbl_bad_we", mem_we, 1'b0);
      end else begin
        chk("tbl_run_we", mem_we, 1'b1);
        chk("tbl_run_dp", done_pulse, 1'b0);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0; #1;
        chk("tbl_abort_en", alg_enable, 4'b0);
      end
      chk("tbl_done_pulse", done_pulse, 1'b1);
      chk("tbl_status", status, vt[i].st);
      chk("tbl_bank", display_bank, 1'b0);
    end
    tick();

    // Full op0 frame: 76800 write cycles, done, swap on vsync 10 cycles later.
    cmd_op = OP_NN; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; #1;
    chk("t1_enable_first", alg_enable, 4'b0001);
    n = 0; we_cnt = 0; en_bad = 0; dp = 0;
    while (n < IMG_OUT_PIX) begin
      if (mem_we) we_cnt++;
      if (alg_enable != 4'b0001) en_bad++;
      if (done_pulse) dp++;
      n++;
      tick();
    end
    alg_done[0] = 1'b1; #1;
    chk("t1_we_on_done", mem_we, 1'b0);
    tick();
    alg_done[0] = 1'b0; #1;
    chk("t1_we_cycles", we_cnt, 76800);
    chk("t1_enable_held", en_bad, 0);
    chk("t1_enable_drop", alg_enable, 4'b0);
    chk("t1_busy_wait", busy, 1'b1);
    for (int c = 0; c < 9; c++) begin
      if (done_pulse) dp++;
      if (display_bank) en_bad++;
      tick();
    end
    chk("t1_no_early_swap", en_bad, 0);
    vsync = 1'b1; #1;
    chk("t1_bank_before_edge", display_bank, 1'b0);
    tick();
    chk("t1_bank_swapped", display_bank, 1'b1);
    chk("t1_write_bank", write_bank, 1'b0);
    chk("t1_status", status, 2'd0);
    chk("t1_ready", cmd_ready, 1'b1);
    if (done_pulse) dp++;
    tick();
    if (done_pulse) dp++;
    chk("t1_done_pulse_once", dp, 1);
    vsync = 1'b0;

    // Asynchronous reset in the middle of a run.
    cmd_op = OP_NN; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("rst_pre_bank", display_bank, 1'b1);
    chk("rst_pre_en", alg_enable, 4'b0001);
    reset_n = 1'b0; #1;
    chk("rst_mid_run",
        {cmd_ready, alg_enable, mem_read_addr, mem_write_addr, mem_wdata, mem_we,
         write_bank, display_bank, busy, done_pulse, status},
        {1'b1, 4'b0, 16'h0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_ready_after", cmd_ready, 1'b1);

    // op1: done and abort together -> done wins, then vsync swaps.
    cmd_op = OP_REPL; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    alg_done[1] = 1'b1; cmd_abort = 1'b1; #1;
    chk("race_we", mem_we, 1'b0);
    tick();
    alg_done[1] = 1'b0; cmd_abort = 1'b0; #1;
    chk("race_busy", busy, 1'b1);
    chk("race_enable", alg_enable, 4'b0);
    chk("race_no_dp", done_pulse, 1'b0);
    tick(); tick();
    chk("race_bank_wait", display_bank, 1'b0);
    vsync = 1'b1;
    tick();
    chk("race_bank_swap", display_bank, 1'b1);
    chk("race_dp", done_pulse, 1'b1);
    chk("race_status", status, 2'd0);
    vsync = 1'b0;
    tick();

    // Abort in WAIT_VSYNC coinciding with a vsync rise: abort wins, no swap.
    cmd_op = OP_REPL; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; alg_done[1] = 1'b1;
    tick();
    alg_done[1] = 1'b0; #1;
    chk("wab_busy", busy, 1'b1);
    tick();
    cmd_abort = 1'b1; vsync = 1'b1;
    tick();
    cmd_abort = 1'b0; #1;
    chk("wab_status", status, 2'd3);
    chk("wab_dp", done_pulse, 1'b1);
    chk("wab_bank", display_bank, 1'b1);
    chk("wab_ready", cmd_ready, 1'b1);
    tick();
    chk("wab_bank_hold", display_bank, 1'b1);
    chk("wab_dp_once", done_pulse, 1'b0);
    vsync = 1'b0;
    tick();

    // Timeout on the 100-cycle instance: op2 engine never finishes.
    chk("to_ready", t_cmd_ready, 1'b1);
    cmd_op = OP_DECIM; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (t_alg_enable == 4'b0100 && n < 200) begin
      n++;
      tick();
    end
    chk("to_run_cycles", n, 100);
    chk("to_dp", t_done_pulse, 1'b1);
    chk("to_status", t_status, 2'd2);
    // That instance swapped once in the done/abort race sequence and never since.
    chk("to_bank", t_display_bank, 1'b1);
    chk("to_main_still_run", alg_enable, 4'b0100);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("to_main_abort", status, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scale_ctrl.md
Name: scale_ctrl

Overview:
- Sequencer for the framebuffer scaling engines: nearest-neighbor zoom, pixel replication, decimation and block average.
- Accepts one resize command at a time and enables exactly one engine.
- Muxes that engine's read/write addresses and pixel onto the shared memory port, and watches for a timeout.
- Swaps the double-buffered display bank on the next vsync rising edge after completion. Sits between the host command interface (HPS/bridge) and the algorithm engines / frame memories.

Parameters:
- NUM_ALG, 4, number of engines; opcode k selects engine k.
- ADDR_W, 16, memory address width.
- PIX_W, 8, pixel width.
- TIMEOUT_CYCLES, 100000, max RUN cycles before abort with timeout; fits in an 18-bit counter.

Ports:
- clk in 1: single system clock.
- reset_n in 1: asynchronous active-low reset.
- cmd_valid in 1: command request.
- cmd_ready out 1: high only in IDLE.
- cmd_op in 3: algorithm opcode.
- cmd_abort in 1: level; abort the current operation.
- vsync in 1: display vertical sync, level, already in clk domain.
- alg_enable out NUM_ALG: one-hot engine enable.
- alg_done in NUM_ALG: per-engine done.
- alg_read_addr in NUM_ALG*ADDR_W: packed, engine k at slice k.
- alg_write_addr in NUM_ALG*ADDR_W: packed.
- alg_pixel in NUM_ALG*PIX_W: packed.
- mem_read_addr out ADDR_W: source memory address.
- mem_write_addr out ADDR_W: destination address.
- mem_wdata out PIX_W: destination pixel.
- mem_we out 1: destination write enable.
- write_bank out 1: back buffer, always equal to ~display_bank.
- display_bank out 1: bank scanned by VGA.
- busy out 1: state != IDLE.
- done_pulse out 1: one-cycle completion strobe.
- status out 2: 0 OK, 1 BAD_OP, 2 TIMEOUT, 3 ABORTED; valid from done_pulse until the next accept.

Behaviour:
- Reset values: state IDLE, alg_enable 0, mem_we 0, mem addresses/data 0, display_bank 0, busy 0, done_pulse 0, status 0, timeout counter 0, vsync edge register 0.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid&&cmd_ready and latch sel=cmd_op.
  - If cmd_op>=NUM_ALG: stay IDLE; done_pulse=1 with status=BAD_OP the next cycle; no engine enabled.
  - Otherwise go to RUN. alg_enable[sel]=1 from the cycle after accept (registered). Counter clears.
- RUN:
  - alg_enable[sel] held at 1; counter increments each cycle.
  - mem_*_addr and mem_wdata are combinationally muxed from slice sel.
  - mem_we = !alg_done[sel].
  - Priority (highest first): alg_done[sel] -> WAIT_VSYNC; cmd_abort -> IDLE with ABORTED; counter==TIMEOUT_CYCLES-1 -> IDLE with TIMEOUT.
  - done and abort in the same cycle: done wins.
  - On leaving RUN, alg_enable drops to 0 the next cycle, which resets the engine pointer.
- WAIT_VSYNC:
  - mem_we=0, alg_enable=0.
  - Edge detect: vs_rise = vsync & ~vsync_q.
  - On vs_rise: display_bank toggles, go IDLE, done_pulse=1, status=OK, all in the same registered update.
  - cmd_abort here: no toggle, go IDLE, status ABORTED.
  - Abort and vs_rise in the same cycle: abort wins and the swap is cancelled.
  - Waits indefinitely for vsync (no timeout).
- Outside RUN, mem_read_addr, mem_write_addr and mem_wdata hold 0.
- done_pulse is exactly one cycle per accepted command. A new command can be accepted the cycle after done_pulse.
- Asynchronous reset mid-operation returns every output to its reset value immediately, including display_bank=0.
- Counter is 18-bit unsigned and saturates; it does not wrap.

Decomposition:
- Shared package scale_pkg holds:
  - State enum: IDLE, RUN, WAIT_VSYNC.
  - Status codes: ST_OK, ST_BAD_OP, ST_TIMEOUT, ST_ABORTED.
  - Opcode constants: OP_NN, OP_REPL, OP_DECIM, OP_AVG.
  - Image-size constants: 160x120 in, 320x240 out.
- One sub-module, scale_port_mux: combinational NUM_ALG-way select of the address/pixel slices and the done bit by sel. The FSM, timeout counter and vsync edge detect stay in scale_ctrl.

Test Plan:
- Reset then cmd op=0. Engine 0 model asserts done after 76800 cycles; vsync rises 10 cycles later. Required: alg_enable=4'b0001 from the cycle after accept; mem_we high for 76800 cycles; display_bank 0->1 on the vs_rise cycle; done_pulse once; status=0.
- cmd op=5 -> cmd_ready stays 1, alg_enable stays 0, done_pulse the next cycle, status=1, display_bank unchanged.
- op=2 with engine 2 never asserting done, TIMEOUT_CYCLES=100 -> alg_enable drops after 100 RUN cycles; status=2; no bank swap.
- op=1, cmd_abort and alg_done[1] in the same cycle -> enters WAIT_VSYNC; the later vsync swaps the bank; status=0. Separately, abort during WAIT_VSYNC -> status=3 with no swap.
- Mux check with op=3 and slices driven to distinct values (read 0x1234, write 0xBEEF, pixel 0xA5) -> mem ports show exactly those values; other slices are ignored.
- reset_n low mid-RUN -> all outputs at reset values asynchronously. After release, cmd_ready=1 and the next command completes normally.
